// File: rtl/bubble_pkg.sv
// Shared definitions for the bubble fetch front end.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package bubble_pkg;

  localparam int DEF_PC_W    = 8;
  localparam int DEF_INSTR_W = 32;

  localparam logic [DEF_PC_W-1:0]    DEF_RESET_PC = '0;
  localparam logic [DEF_INSTR_W-1:0] NOP_INSTR    = '0;

  // One prefetched instruction together with the address it came from.
  typedef struct packed {
    logic [DEF_PC_W-1:0]    pc;
    logic [DEF_INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/bubble_fetch_fifo.sv
// Synchronous DEPTH-entry FIFO with push, pop, flush and occupancy count.
// Latency: a push is visible at head_dat the cycle after it is written.
// Backpressure: none internally; the caller must never push when full. Flush wins over push/pop.
// Ports: clk/reset, flush, push + push_dat, pop, head_dat, count, empty.
module bubble_fetch_fifo
  import bubble_pkg::*;
#(
  parameter type entry_t = fetch_entry_t,
  parameter int  DEPTH   = 4,
  localparam int AW      = $clog2(DEPTH),
  localparam int CW      = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  entry_t        push_dat,
  input  logic          pop,
  output entry_t        head_dat,
  output logic [CW-1:0] count,
  output logic          empty
);

  entry_t        mem_q [DEPTH];
  entry_t        mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  always_comb begin
    do_push  = push & !flush;
    do_pop   = pop & !flush & (count_q != '0);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_dat;
        wr_ptr_d        = wr_ptr_q + 1'b1;  // power-of-two depth: natural wrap
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: its contents are only observed through a non-empty head.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head_dat = mem_q[rd_ptr_q];
  assign count    = count_q;
  assign empty    = (count_q == '0);

endmodule

// File: rtl/bubble_fetch_unit.sv
// Instruction fetch front end: issues imem reads, buffers {pc, instr} in a prefetch FIFO, hands them to decode.
// Latency: read issued in cycle 0, data in cycle 1, if_valid in cycle 2; one instruction per cycle steady state.
// Backpressure: id_ready=0 fills the FIFO; reads stop when count + in-flight read reaches DEPTH.
// Ports: clk/reset (async active-low), imem_rd_en/imem_addr/imem_rdata, redirect_valid/redirect_pc,
//        if_valid/if_instr/if_pc/id_ready toward decode, fifo_count occupancy.
module bubble_fetch_unit
  import bubble_pkg::*;
#(
  parameter int              PC_W     = DEF_PC_W,
  parameter int              INSTR_W  = DEF_INSTR_W,
  parameter int              DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(DEF_RESET_PC),
  localparam int             CW       = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_rd_en,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [PC_W-1:0]    if_pc,
  input  logic               id_ready,
  output logic [CW-1:0]      fifo_count
);

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0] pending_pc_q, pending_pc_d;
  logic            pending_q, pending_d;
  logic [CW-1:0]   occupancy;
  logic            fifo_empty;
  logic            pop;
  entry_t          push_dat;
  entry_t          head_dat;

  always_comb begin
    // The in-flight read already owns a slot, so it is counted before issuing another.
    occupancy  = fifo_count + CW'(pending_q);
    imem_rd_en = reset & !redirect_valid & (occupancy < CW'(DEPTH));
    imem_addr  = fetch_pc_q;

    // A redirect hides the head so decode cannot consume a soon-to-be-flushed entry.
    if_valid = !redirect_valid & !fifo_empty;
    if_pc    = fifo_empty ? '0 : head_dat.pc;
    if_instr = fifo_empty ? INSTR_W'(NOP_INSTR) : head_dat.instr;
    pop      = if_valid & id_ready;

    push_dat.pc    = pending_pc_q;
    push_dat.instr = imem_rdata;

    fetch_pc_d = fetch_pc_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
    end else if (imem_rd_en) begin
      fetch_pc_d = fetch_pc_q + 1'b1;
    end

    // imem_rd_en is already low during a redirect, which squashes any in-flight read.
    pending_d    = imem_rd_en;
    pending_pc_d = imem_rd_en ? fetch_pc_q : pending_pc_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q   <= RESET_PC;
      pending_q    <= 1'b0;
      pending_pc_q <= '0;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      pending_q    <= pending_d;
      pending_pc_q <= pending_pc_d;
    end
  end

  bubble_fetch_fifo #(
    .entry_t (entry_t),
    .DEPTH   (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .flush    (redirect_valid),
    .push     (pending_q),
    .push_dat (push_dat),
    .pop      (pop),
    .head_dat (head_dat),
    .count    (fifo_count),
    .empty    (fifo_empty)
  );

endmodule

// File: tb/tb_bubble_fetch_unit.sv
// Directed bench for bubble_fetch_unit: table-driven cycle vectors plus a hand-written
// asynchronous-reset sequence. imem model returns 0x1000 + address one cycle after a read.
module tb_bubble_fetch_unit;

  localparam int PC_W    = 8;
  localparam int INSTR_W = 32;
  localparam int DEPTH   = 4;
  localparam int CW      = 3;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               imem_rd_en;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_rdata = '0;
  logic               redirect_valid = 1'b0;
  logic [PC_W-1:0]    redirect_pc = '0;
  logic               if_valid;
  logic [INSTR_W-1:0] if_instr;
  logic [PC_W-1:0]    if_pc;
  logic               id_ready = 1'b0;
  logic [CW-1:0]      fifo_count;

  always #5 clk = ~clk;

  bubble_fetch_unit #(
    .PC_W     (PC_W),
    .INSTR_W  (INSTR_W),
    .DEPTH    (DEPTH),
    .RESET_PC (8'h00)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_rd_en     (imem_rd_en),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .id_ready       (id_ready),
    .fifo_count     (fifo_count)
  );

  // Synchronous-read instruction memory.
  always @(posedge clk) begin
    if (imem_rd_en) imem_rdata <= 32'h1000 + 32'(imem_addr);
  end

  typedef struct {
    logic       rv;
    logic [7:0] rpc;
    logic       rdy;
    logic       exp_rd;
    logic [7:0] exp_addr;
    logic       exp_v;
    logic [7:0] exp_pc;
    logic [2:0] exp_cnt;
  } vec_t;

  vec_t tbl_a[$];
  vec_t tbl_b[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(input logic rv, input logic [7:0] rpc, input logic rdy,
                              input logic exp_rd, input logic [7:0] exp_addr,
                              input logic exp_v, input logic [7:0] exp_pc, input logic [2:0] exp_cnt);
    vec_t v;
    v.rv = rv; v.rpc = rpc; v.rdy = rdy; v.exp_rd = exp_rd; v.exp_addr = exp_addr;
    v.exp_v = exp_v; v.exp_pc = exp_pc; v.exp_cnt = exp_cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at posedge+1; leaves the bench at posedge+1 of the next cycle.
  task automatic run_vec(input vec_t v, input string seg, input int idx);
    redirect_valid = v.rv;
    redirect_pc    = v.rpc;
    id_ready       = v.rdy;
    @(negedge clk);
    chk($sformatf("%s[%0d] imem_rd_en", seg, idx), 32'(imem_rd_en), 32'(v.exp_rd));
    chk($sformatf("%s[%0d] imem_addr", seg, idx), 32'(imem_addr), 32'(v.exp_addr));
    chk($sformatf("%s[%0d] if_valid", seg, idx), 32'(if_valid), 32'(v.exp_v));
    chk($sformatf("%s[%0d] fifo_count", seg, idx), 32'(fifo_count), 32'(v.exp_cnt));
    if (v.exp_v) begin
      chk($sformatf("%s[%0d] if_pc", seg, idx), 32'(if_pc), 32'(v.exp_pc));
      chk($sformatf("%s[%0d] if_instr", seg, idx), if_instr, 32'h1000 + 32'(v.exp_pc));
    end
    @(posedge clk);
    #1;
  endtask

  // Holds reset across one edge, checks the reset state, releases at posedge+1.
  task automatic do_reset(input string seg);
    reset          = 1'b0;
    redirect_valid = 1'b0;
    id_ready       = 1'b0;
    @(negedge clk);
    chk({seg, " rst imem_rd_en"}, 32'(imem_rd_en), 32'h0);
    chk({seg, " rst if_valid"}, 32'(if_valid), 32'h0);
    chk({seg, " rst if_pc"}, 32'(if_pc), 32'h0);
    chk({seg, " rst if_instr"}, if_instr, 32'h0);
    chk({seg, " rst fifo_count"}, 32'(fifo_count), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    // Segment A: streaming with decode always ready.
    for (int c = 0; c < 8; c++) begin
      tbl_a.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 8'(c), (c >= 2), 8'(c - 2), (c >= 2) ? 3'd1 : 3'd0));
    end

    // Segment B: fill/stall, single pop, redirects, back-to-back redirects, PC wrap.
    //                  rv   rpc    rdy   rd    addr   v     pc     cnt
    tbl_b.push_back(mk(1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 3'd0)); // c0
    tbl_b.push_back(mk(1'b0, 8'h00, 1'b0, 1'b1, 8'h01, 1'b0, 8'h00, 3'd0));
    tbl_b.push_back(mk(1'b0, 8'h00, 1'b0, 1'b1, 8'h02, 1'b1, 8'h00, 3'd1));
    tbl_b.push_back(mk(1'b0, 8'h00, 1'b0, 1'b1, 8'h03, 1'b1, 8'h00, 3'd2));
    tbl_b.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 8'h04, 1'b1, 8'h00, 3'd3)); // count+pending = 4
    tbl_b.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 8'h04, 1'b1, 8'h00, 3'd4)); // c5 full
    tbl_b.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 8'h04, 1'b1, 8'h00, 3'd4)); // single pop
    tbl_b.push_back(mk(1'b0, 8'h00, 1'b0, 1'b1, 8'h04, 1'b1, 8'h01, 3'd3)); // one read at 4
    tbl_b.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 8'h05, 1'b1, 8'h01, 3'd3));
    tbl_b.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 8'h05, 1'b1, 8'h01, 3'd4));
    tbl_b.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 8'h05, 1'b1, 8'h01, 3'd4)); // c10
    tbl_b.push_back(mk(1'b0, 8'h00, 1'b0, 1'b1, 8'h05, 1'b1, 8'h02, 3'd3));
    tbl_b.push_back(mk(1'b1, 8'h40, 1'b1, 1'b0, 8'h06, 1'b0, 8'h00, 3'd3)); // 3 entries + pending, redirect
    tbl_b.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 8'h40, 1'b0, 8'h00, 3'd0));
    tbl_b.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 8'h41, 1'b0, 8'h00, 3'd0));
    tbl_b.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 8'h42, 1'b1, 8'h40, 3'd1)); // c15
    tbl_b.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 8'h43, 1'b1, 8'h41, 3'd1));
    tbl_b.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 8'h44, 1'b1, 8'h42, 3'd1));
    tbl_b.push_back(mk(1'b1, 8'h20, 1'b1, 1'b0, 8'h45, 1'b0, 8'h00, 3'd1)); // redirect 0x20
    tbl_b.push_back(mk(1'b1, 8'h30, 1'b1, 1'b0, 8'h20, 1'b0, 8'h00, 3'd0)); // redirect 0x30 wins
    tbl_b.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 8'h30, 1'b0, 8'h00, 3'd0)); // c20
    tbl_b.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 8'h31, 1'b0, 8'h00, 3'd0));
    tbl_b.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 8'h32, 1'b1, 8'h30, 3'd1));
    tbl_b.push_back(mk(1'b1, 8'hFE, 1'b1, 1'b0, 8'h33, 1'b0, 8'h00, 3'd1)); // redirect 0xFE
    tbl_b.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 8'hFE, 1'b0, 8'h00, 3'd0));
    tbl_b.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 8'hFF, 1'b0, 8'h00, 3'd0)); // c25
    tbl_b.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 8'hFE, 3'd1));
    tbl_b.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 8'h01, 1'b1, 8'hFF, 3'd1));
    tbl_b.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 8'h02, 1'b1, 8'h00, 3'd1));
    tbl_b.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 8'h03, 1'b1, 8'h01, 3'd1)); // c29

    do_reset("A");
    foreach (tbl_a[i]) run_vec(tbl_a[i], "A", i);

    do_reset("B");
    foreach (tbl_b[i]) run_vec(tbl_b[i], "B", i);

    // Fill to DEPTH with decode stalled: head pc 0x02, fetch_pc 0x06.
    redirect_valid = 1'b0;
    id_ready       = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    @(negedge clk);
    chk("full fifo_count", 32'(fifo_count), 32'd4);
    chk("full if_pc", 32'(if_pc), 32'h02);
    chk("full imem_rd_en", 32'(imem_rd_en), 32'h0);
    chk("full imem_addr", 32'(imem_addr), 32'h06);

    // Asynchronous reset between edges: outputs clear without a clock edge.
    #2;
    reset = 1'b0;
    #1;
    chk("async imem_rd_en", 32'(imem_rd_en), 32'h0);
    chk("async if_valid", 32'(if_valid), 32'h0);
    chk("async if_pc", 32'(if_pc), 32'h0);
    chk("async if_instr", if_instr, 32'h0);
    chk("async fifo_count", 32'(fifo_count), 32'h0);
    @(posedge clk);
    #1;
    chk("held fifo_count", 32'(fifo_count), 32'h0);
    chk("held imem_addr", 32'(imem_addr), 32'h00);
    reset    = 1'b1;
    id_ready = 1'b1;
    @(negedge clk);
    chk("restart c0 imem_rd_en", 32'(imem_rd_en), 32'h1);
    chk("restart c0 imem_addr", 32'(imem_addr), 32'h00);
    chk("restart c0 if_valid", 32'(if_valid), 32'h0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("restart c1 imem_addr", 32'(imem_addr), 32'h01);
    chk("restart c1 if_valid", 32'(if_valid), 32'h0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("restart c2 if_valid", 32'(if_valid), 32'h1);
    chk("restart c2 if_pc", 32'(if_pc), 32'h00);
    chk("restart c2 if_instr", if_instr, 32'h1000);
    chk("restart c2 fifo_count", 32'(fifo_count), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
